// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter
// Brief    : Round-robin CPU/debug arbiter and one-shot sequencer for data_mem.
//            Optional bounds check enabled by defining DMEM_ARB_BOUNDS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_arbiter #(
    parameter int DEPTH      = 256,
    parameter int ADDR_SHIFT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  req,
    input  logic [1:0]  we,
    input  logic [31:0] addr0,
    input  logic [31:0] addr1,
    input  logic [31:0] wdata0,
    input  logic [31:0] wdata1,
    output logic [1:0]  ack,
    output logic [1:0]  rvalid,
    output logic [31:0] rdata,
    output logic [1:0]  err,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_address,
    output logic [31:0] mem_data_in,
    input  logic [31:0] mem_data_out
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_RDATA  = 2'd2;

    if (DEPTH < 1 || ADDR_SHIFT < 0 || ADDR_SHIFT > 31) begin : g_bad_params
        $error("dmem_arbiter: DEPTH must be >= 1 and ADDR_SHIFT in 0..31");
    end

    logic [1:0]  state_q, state_d;
    logic        last_owner_q, last_owner_d;
    logic        owner_q, owner_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;

    logic        w_grant_sel;
    logic [31:0] w_sel_word;
    logic        w_oob;
    logic [1:0]  w_owner_onehot;

    // On a tie the requester that did not own the last access wins.
    assign w_grant_sel    = (req == 2'b11) ? ~last_owner_q : req[1];
    assign w_sel_word     = (w_grant_sel ? addr1 : addr0) >> ADDR_SHIFT;
    assign w_owner_onehot = owner_q ? 2'b10 : 2'b01;

`ifdef DMEM_ARB_BOUNDS_EN
    localparam logic [31:0] DEPTH_W = 32'(DEPTH);
    logic oob_q, oob_d;

    assign w_oob = oob_q;
`else
    assign w_oob = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            last_owner_q <= 1'b1;
            owner_q      <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
`ifdef DMEM_ARB_BOUNDS_EN
            oob_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            last_owner_q <= last_owner_d;
            owner_q      <= owner_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rdata_q      <= rdata_d;
`ifdef DMEM_ARB_BOUNDS_EN
            oob_q        <= oob_d;
`endif
        end
    end

    // Next-state logic
    always_comb begin
        state_d      = state_q;
        last_owner_d = last_owner_q;
        owner_d      = owner_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rdata_d      = rdata_q;
`ifdef DMEM_ARB_BOUNDS_EN
        oob_d        = oob_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (|req) begin
                    owner_d = w_grant_sel;
                    we_d    = w_grant_sel ? we[1] : we[0];
                    addr_d  = w_sel_word;
                    wdata_d = w_grant_sel ? wdata1 : wdata0;
`ifdef DMEM_ARB_BOUNDS_EN
                    oob_d   = (w_sel_word >= DEPTH_W);
`endif
                    state_d = S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (we_q || w_oob) begin
                    last_owner_d = owner_q;
                    state_d      = S_IDLE;
                end else begin
                    state_d = S_RDATA;
                end
            end
            S_RDATA: begin
                rdata_d      = mem_data_out;
                last_owner_d = owner_q;
                state_d      = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs decode from state and latches only, so reset clears them at once.
    always_comb begin
        ack         = 2'b00;
        rvalid      = 2'b00;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        mem_address = '0;
        mem_data_in = '0;
        rdata       = rdata_q;
        case (state_q)
            S_ACCESS: begin
                mem_address = addr_q;
                mem_data_in = wdata_q;
                if (!w_oob) begin
                    ack       = w_owner_onehot;
                    mem_write = we_q;
                    mem_read  = ~we_q;
                end
            end
            S_RDATA: begin
                rvalid = w_owner_onehot;
                rdata  = mem_data_out;
            end
            default: begin
                ack = 2'b00;
            end
        endcase
    end

`ifdef DMEM_ARB_BOUNDS_EN
    assign err = (state_q == S_ACCESS && w_oob) ? w_owner_onehot : 2'b00;
`else
    assign err = 2'b00;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_arbiter
// Brief    : Directed self-checking bench for dmem_arbiter with a data_mem model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

    logic        clk;
    logic        rst;
    logic [1:0]  req;
    logic [1:0]  we;
    logic [31:0] addr0, addr1, wdata0, wdata1;
    logic [1:0]  ack, rvalid, err;
    logic [31:0] rdata;
    logic        mem_read, mem_write;
    logic [31:0] mem_address, mem_data_in, mem_data_out;

    int vectors;
    int miscompares;

    logic [31:0] mem [0:511];

    dmem_arbiter #(.DEPTH(256), .ADDR_SHIFT(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .we           (we),
        .addr0        (addr0),
        .addr1        (addr1),
        .wdata0       (wdata0),
        .wdata1       (wdata1),
        .ack          (ack),
        .rvalid       (rvalid),
        .rdata        (rdata),
        .err          (err),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_address  (mem_address),
        .mem_data_in  (mem_data_in),
        .mem_data_out (mem_data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // data_mem model: synchronous write, registered read data
    initial begin
        for (int i = 0; i < 512; i++) mem[i] = 32'h0;
        mem_data_out = 32'h0;
    end
    always @(posedge clk) begin
        if (mem_write) mem[mem_address[8:0]] <= mem_data_in;
        if (mem_read)  mem_data_out <= mem[mem_address[8:0]];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 2'b00; we = 2'b00;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        tick(); tick();
        vectors++;
        if ({ack, rvalid, err, mem_read, mem_write} !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_ctrl got=%b exp=%b", {ack, rvalid, err, mem_read, mem_write}, 8'h00);
        end
        vectors++;
        if ({mem_address, mem_data_in, rdata} !== 96'h0) begin
            miscompares++;
            $display("FAIL reset_data got=%h/%h/%h exp=0", mem_address, mem_data_in, rdata);
        end
        rst = 1'b0;
    endtask

    task automatic test_cpu_write();
        req = 2'b01; we = 2'b01; addr0 = 32'h10; wdata0 = 32'hDEADBEEF;
        tick();
        vectors++;
        if ({ack, mem_write, mem_read, mem_address, mem_data_in} !== {2'b01, 1'b1, 1'b0, 32'd4, 32'hDEADBEEF}) begin
            miscompares++;
            $display("FAIL wr_access got ack=%b wr=%b rd=%b a=%h d=%h exp ack=01 wr=1 rd=0 a=4 d=deadbeef",
                     ack, mem_write, mem_read, mem_address, mem_data_in);
        end
        req = 2'b00;
        tick();
        vectors++;
        if ({ack, mem_write, mem_read, rvalid} !== 6'b0) begin
            miscompares++;
            $display("FAIL wr_idle got ack=%b wr=%b rd=%b rv=%b exp all 0", ack, mem_write, mem_read, rvalid);
        end
    endtask

    task automatic test_cpu_read();
        req = 2'b01; we = 2'b00; addr0 = 32'h10;
        tick();
        vectors++;
        if ({ack, mem_read, mem_write, mem_address} !== {2'b01, 1'b1, 1'b0, 32'd4}) begin
            miscompares++;
            $display("FAIL rd_access got ack=%b rd=%b wr=%b a=%h exp ack=01 rd=1 wr=0 a=4",
                     ack, mem_read, mem_write, mem_address);
        end
        req = 2'b00;
        tick();
        vectors++;
        if ({rvalid, ack, rdata} !== {2'b01, 2'b00, 32'hDEADBEEF}) begin
            miscompares++;
            $display("FAIL rd_data got rv=%b ack=%b rdata=%h exp rv=01 ack=00 rdata=deadbeef", rvalid, ack, rdata);
        end
        tick();
        vectors++;
        if ({rvalid, rdata} !== {2'b00, 32'hDEADBEEF}) begin
            miscompares++;
            $display("FAIL rd_hold got rv=%b rdata=%h exp rv=00 rdata=deadbeef", rvalid, rdata);
        end
    endtask

    task automatic test_contention();
        logic [1:0]  exp_ack;
        logic [31:0] exp_addr;
        rst = 1'b1; #1; rst = 1'b0;
        req = 2'b11; we = 2'b11;
        addr0 = 32'h20; wdata0 = 32'hAAAA0000;
        addr1 = 32'h24; wdata1 = 32'hBBBB1111;
        for (int g = 0; g < 4; g++) begin
            exp_ack  = (g % 2 == 0) ? 2'b01 : 2'b10;
            exp_addr = (g % 2 == 0) ? 32'd8 : 32'd9;
            tick();
            vectors++;
            if ({ack, mem_write, mem_address} !== {exp_ack, 1'b1, exp_addr}) begin
                miscompares++;
                $display("FAIL rr_grant%0d got ack=%b wr=%b a=%h exp ack=%b wr=1 a=%h",
                         g, ack, mem_write, mem_address, exp_ack, exp_addr);
            end
            if (g == 3) req = 2'b00;
            tick();
            vectors++;
            if ({ack, mem_write} !== 3'b000) begin
                miscompares++;
                $display("FAIL rr_gap%0d got ack=%b wr=%b exp ack=00 wr=0", g, ack, mem_write);
            end
        end
    endtask

    task automatic test_back_to_back();
        req = 2'b01; we = 2'b01; addr0 = 32'h30; wdata0 = 32'h12345678;
        tick();
        vectors++;
        if ({ack, mem_write} !== 3'b011) begin
            miscompares++;
            $display("FAIL b2b_cpu_ack got ack=%b wr=%b exp ack=01 wr=1", ack, mem_write);
        end
        req = 2'b10; we = 2'b00; addr1 = 32'h20;
        tick();
        vectors++;
        if (ack !== 2'b00) begin
            miscompares++;
            $display("FAIL b2b_idle got ack=%b exp 00", ack);
        end
        tick();
        vectors++;
        if ({ack, mem_read, mem_address} !== {2'b10, 1'b1, 32'd8}) begin
            miscompares++;
            $display("FAIL b2b_dbg_ack got ack=%b rd=%b a=%h exp ack=10 rd=1 a=8", ack, mem_read, mem_address);
        end
        req = 2'b00;
        tick();
        vectors++;
        if ({rvalid, rdata} !== {2'b10, 32'hAAAA0000}) begin
            miscompares++;
            $display("FAIL b2b_dbg_data got rv=%b rdata=%h exp rv=10 rdata=aaaa0000", rvalid, rdata);
        end
        tick();
        vectors++;
        if ({rvalid, ack} !== 4'b0000) begin
            miscompares++;
            $display("FAIL b2b_after got rv=%b ack=%b exp 00/00", rvalid, ack);
        end
    endtask

    task automatic test_reset_mid_access();
        req = 2'b01; we = 2'b00; addr0 = 32'h30;
        tick();
        vectors++;
        if (mem_read !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_pre got rd=%b exp 1", mem_read);
        end
        #1 rst = 1'b1; req = 2'b00;
        #1;
        vectors++;
        if ({mem_read, ack, mem_address} !== {1'b0, 2'b00, 32'd0}) begin
            miscompares++;
            $display("FAIL mid_async got rd=%b ack=%b a=%h exp 0/00/0", mem_read, ack, mem_address);
        end
        tick();
        rst = 1'b0;
        tick();
        vectors++;
        if ({rvalid, ack} !== 4'b0000) begin
            miscompares++;
            $display("FAIL mid_norv got rv=%b ack=%b exp 00/00", rvalid, ack);
        end
        req = 2'b11; we = 2'b11;
        addr0 = 32'h40; wdata0 = 32'hC0C0C0C0;
        addr1 = 32'h44; wdata1 = 32'hD0D0D0D0;
        tick();
        vectors++;
        if ({ack, mem_address} !== {2'b01, 32'd16}) begin
            miscompares++;
            $display("FAIL mid_tie got ack=%b a=%h exp ack=01 a=10", ack, mem_address);
        end
        req = 2'b00;
        tick();
    endtask

    task automatic test_bounds();
        req = 2'b10; we = 2'b00; addr1 = 32'h400;
        tick();
`ifdef DMEM_ARB_BOUNDS_EN
        vectors++;
        if ({err, ack, mem_read, mem_write} !== {2'b10, 2'b00, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL oob_access got err=%b ack=%b rd=%b wr=%b exp 10/00/0/0", err, ack, mem_read, mem_write);
        end
        req = 2'b00;
        tick();
        vectors++;
        if ({rvalid, err} !== 4'b0000) begin
            miscompares++;
            $display("FAIL oob_after got rv=%b err=%b exp 00/00", rvalid, err);
        end
`else
        vectors++;
        if ({err, ack, mem_read, mem_address} !== {2'b00, 2'b10, 1'b1, 32'd256}) begin
            miscompares++;
            $display("FAIL w256_access got err=%b ack=%b rd=%b a=%h exp 00/10/1/100",
                     err, ack, mem_read, mem_address);
        end
        req = 2'b00;
        tick();
        vectors++;
        if ({rvalid, err, rdata} !== {2'b10, 2'b00, 32'h0}) begin
            miscompares++;
            $display("FAIL w256_data got rv=%b err=%b rdata=%h exp 10/00/0", rvalid, err, rdata);
        end
        tick();
`endif
        req = 2'b11; we = 2'b11;
        tick();
        vectors++;
        if (ack !== 2'b01) begin
            miscompares++;
            $display("FAIL bounds_tie got ack=%b exp 01", ack);
        end
        req = 2'b00;
        tick();
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_cpu_write();
        test_cpu_read();
        test_contention();
        test_back_to_back();
        test_reset_mid_access();
        test_bounds();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
